// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to IM from address 0 and holds the core until complete.
module im_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   n_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [31:0]       checksum
);

    localparam int unsigned NW_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic            load, accept, last;
    logic [NW_W-1:0] n_lat;
    logic [NW_W-1:0] word_idx;
    logic [1:0]      byte_cnt;
    logic [23:0]     part_word;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        last      = (word_idx == (n_lat - NW_W'(1)));
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (n_words == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                accept = byte_valid && byte_ready;
                if (accept && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = last ? S_DONE : S_COLLECT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
            checksum   <= '0;
            n_lat      <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            part_word  <= '0;
        end else begin
            byte_ready <= (state_nxt == S_COLLECT);
            im_we      <= (state_nxt == S_WRITE);
            busy       <= (state_nxt == S_COLLECT) || (state_nxt == S_WRITE);
            done       <= (state_nxt == S_DONE);
            cpu_hold   <= (state_nxt != S_DONE);

            if (load) begin
                n_lat    <= (n_words > NW_W'(DEPTH)) ? NW_W'(DEPTH) : n_words;
                checksum <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
            end

            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: part_word[7:0]   <= byte_data;
                    2'd1: part_word[15:8]  <= byte_data;
                    2'd2: part_word[23:16] <= byte_data;
                    default: begin
                        im_wdata <= {byte_data, part_word};
                        im_addr  <= word_idx[ADDR_W-1:0];
                    end
                endcase
            end

            if (state == S_WRITE) begin
                checksum <= checksum ^ im_wdata;
                word_idx <= word_idx + NW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: expected IM writes go into a scoreboard queue when
// bytes are queued and are popped by a write monitor.
module tb_im_loader;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   n_words = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic [31:0]       checksum;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int wr_count = 0;
    wr_t exp_q[$];

    im_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .n_words(n_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy),
        .done(done), .cpu_hold(cpu_hold), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every IM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_t e;
            wr_count++;
            last_we_cyc = cyc;
            total++;
            if (byte_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL write_cycle_flags: byte_ready=%b busy=%b required 0/1", byte_ready, busy);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%0d data=%08h with no write expected", im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                if (im_addr !== e.a || im_wdata !== e.d) begin
                    bad++;
                    $display("FAIL write: addr=%0d data=%08h required addr=%0d data=%08h", im_addr, im_wdata, e.a, e.d);
                end
            end
        end
    end

    function automatic logic [31:0] word_of(input logic [7:0] b[$], input int w);
        return {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_load(input int n);
        @(negedge clk);
        start = 1'b1;
        n_words = (ADDR_W+1)'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers bytes; returns on the negedge where the last byte is committed to be taken.
    task automatic stream(input logic [7:0] b[$], input bit toggle);
        int i = 0;
        int budget = 0;
        bit phase = 1'b1;
        while (i < b.size()) begin
            @(negedge clk);
            byte_valid = toggle ? phase : 1'b1;
            byte_data  = b[i];
            phase = ~phase;
            if (byte_valid && byte_ready === 1'b1) i++;
            budget++;
            if (budget > 4000) begin
                bad++; total++;
                $display("FAIL stream_timeout: accepted=%0d required=%0d", i, b.size());
                break;
            end
        end
    endtask

    task automatic wait_done(input string name, input bit check_lat, input logic [31:0] exp_sum);
        int n = 0;
        @(negedge clk);
        byte_valid = 1'b0;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout: done=%b required 1", name, done);
        end
        if (check_lat) begin
            total++;
            if (cyc !== last_we_cyc + 1) begin
                bad++;
                $display("FAIL %s_done_latency: done at cycle %0d required %0d", name, cyc, last_we_cyc + 1);
            end
        end
        total++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0 || checksum !== exp_sum) begin
            bad++;
            $display("FAIL %s_final: cpu_hold=%b busy=%b checksum=%08h required 0/0/%08h", name, cpu_hold, busy, checksum, exp_sum);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_writes: %0d pending required 0", name, exp_q.size());
        end
    endtask

    task automatic check_reset_vals(input string name);
        total++;
        if (byte_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== '0 || im_wdata !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1 || checksum !== '0) begin
            bad++;
            $display("FAIL %s: br=%b we=%b addr=%0d wd=%08h busy=%b done=%b hold=%b sum=%08h required 0/0/0/0/0/0/1/0",
                     name, byte_ready, im_we, im_addr, im_wdata, busy, done, cpu_hold, checksum);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        check_reset_vals("reset_values");
    endtask

    task automatic test_basic(input bit toggle, input string name);
        logic [7:0] b[$] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_q.push_back('{a: 6'd0, d: 32'h0000_0013});
        exp_q.push_back('{a: 6'd1, d: 32'h0010_0093});
        start_load(2);
        stream(b, toggle);
        wait_done(name, 1'b1, 32'h0010_0080);
    endtask

    task automatic test_zero();
        int w0;
        do_reset();
        w0 = wr_count;
        start_load(0);
        total++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || checksum !== 32'h0) begin
            bad++;
            $display("FAIL zero_words: done=%b hold=%b sum=%08h required 1/0/00000000", done, cpu_hold, checksum);
        end
        repeat (3) @(negedge clk);
        total++;
        if (wr_count !== w0) begin
            bad++;
            $display("FAIL zero_words_writes: %0d writes required 0", wr_count - w0);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] b[$];
        logic [31:0] sum = '0;
        int w0 = wr_count;
        for (int i = 0; i < 256; i++) b.push_back(8'($urandom_range(0, 255)));
        for (int w = 0; w < 64; w++) begin
            exp_q.push_back('{a: 6'(w), d: word_of(b, w)});
            sum ^= word_of(b, w);
        end
        start_load(70);
        stream(b, 1'b0);
        wait_done("clamp", 1'b1, sum);
        total++;
        if (wr_count - w0 !== 64) begin
            bad++;
            $display("FAIL clamp_count: %0d writes required 64", wr_count - w0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data = 8'hAA;
            total++;
            if (byte_ready !== 1'b0) begin
                bad++;
                $display("FAIL clamp_extra_ready: byte_ready=%b required 0", byte_ready);
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        logic [7:0] b2[$] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        exp_q.push_back('{a: 6'd0, d: 32'h0403_0201});
        start_load(3);
        stream(b, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset_mid_load");
        exp_q.push_back('{a: 6'd0, d: 32'hDEAD_BEEF});
        start_load(1);
        stream(b2, 1'b0);
        wait_done("after_reset", 1'b1, 32'hDEAD_BEEF);
    endtask

    task automatic test_start_ignored();
        logic [7:0] a[$] = '{8'h11, 8'h22};
        logic [7:0] r[$] = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic [7:0] c[$] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        exp_q.push_back('{a: 6'd0, d: 32'h4433_2211});
        exp_q.push_back('{a: 6'd1, d: 32'h8877_6655});
        start_load(2);
        stream(a, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        n_words = 7'd1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL start_in_collect: busy=%b ready=%b done=%b required 1/1/0", busy, byte_ready, done);
        end
        stream(r, 1'b1);
        wait_done("start_ignored", 1'b1, 32'h4433_2211 ^ 32'h8877_6655);
        exp_q.push_back('{a: 6'd0, d: 32'h3CC3_5AA5});
        start_load(1);
        total++;
        if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1 || checksum !== 32'h0) begin
            bad++;
            $display("FAIL restart_from_done: done=%b hold=%b busy=%b sum=%08h required 0/1/1/00000000", done, cpu_hold, busy, checksum);
        end
        stream(c, 1'b0);
        wait_done("reload", 1'b1, 32'h3CC3_5AA5);
    endtask

    initial begin
        test_reset();
        test_basic(1'b0, "basic");
        do_reset();
        test_basic(1'b1, "toggle");
        test_zero();
        test_clamp();
        test_reset_mid();
        test_start_ignored();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
